// File: rtl/pcs_tx_byte_sequencer.sv
// pcs_tx_byte_sequencer
//   TX-side PCS front end. Takes PIPE TX words (8/16/32 bit) over a
//   valid/ready handshake and serialises them to one byte per WordClk for
//   the 8b/10b encoder, LSB byte first, each byte carrying its K flag.
//   With TX_SKP_INSERT_EN defined, SKP ordered sets (COM followed by
//   SKP_COUNT x K28.0) are inserted at word boundaries every SKP_INTERVAL
//   symbol times so the far-end elastic buffer can compensate clock drift.
//   Without the macro the block is a pure width down-converter.
//
// Ports
//   WordClk       symbol clock, the only clock
//   Rst_n         synchronous active-low reset
//   DataBusWidth  PIPE width 8/16/32; any other value behaves as 8
//   TX_Data       TX word, bytes above the active width ignored
//   TX_DataK      per-byte K flags
//   TX_Valid      upstream word valid
//   TX_Ready      block accepts a word this cycle (combinational)
//   Data_out      byte to the encoder (registered)
//   DataK_out     Data_out is a control symbol (registered)
//   Out_Valid     Data_out/DataK_out valid (registered)
//   Skp_Inserted  one-cycle pulse alongside the COM of an inserted SKP set
module pcs_tx_byte_sequencer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int CNT_W        = 11
) (
  input  logic        WordClk,
  input  logic        Rst_n,
  input  logic [5:0]  DataBusWidth,
  input  logic [31:0] TX_Data,
  input  logic [3:0]  TX_DataK,
  input  logic        TX_Valid,
  output logic        TX_Ready,
  output logic [7:0]  Data_out,
  output logic        DataK_out,
  output logic        Out_Valid,
  output logic        Skp_Inserted
);

  typedef enum logic [1:0] {IDLE, SHIFT, SKP_COM, SKP_SYM} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  wordk_q, wordk_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        datak_q, datak_d;
  logic        out_valid_q, out_valid_d;
  logic        skp_due;
  logic        accept;
  logic        at_last;

  // Index of the final byte of a word for the requested bus width.
  function automatic logic [1:0] width_last(input logic [5:0] w);
    case (w)
      6'd16:   return 2'd1;
      6'd32:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

`ifdef TX_SKP_INSERT_EN
  localparam logic [2:0]       SKP_LAST = 3'(SKP_COUNT - 1);
  localparam logic [CNT_W-1:0] SKP_INT  = CNT_W'(SKP_INTERVAL);

  logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
  logic [2:0]       skp_idx_q, skp_idx_d;
  logic             skp_ins_q, skp_ins_d;

  assign skp_due = (skp_cnt_q >= SKP_INT);

  // Counter is zero while COM is on the wire, then counts up and saturates.
  always_comb begin
    if (state_d == SKP_COM)  skp_cnt_d = '0;
    else if (skp_due)        skp_cnt_d = skp_cnt_q;
    else                     skp_cnt_d = skp_cnt_q + 1'b1;
  end

  always_ff @(posedge WordClk) begin
    if (!Rst_n) begin
      skp_cnt_q <= '0;
      skp_idx_q <= '0;
      skp_ins_q <= 1'b0;
    end else begin
      skp_cnt_q <= skp_cnt_d;
      skp_idx_q <= skp_idx_d;
      skp_ins_q <= skp_ins_d;
    end
  end

  assign Skp_Inserted = skp_ins_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^{CNT_W'(SKP_INTERVAL), 3'(SKP_COUNT)};
  assign skp_due      = 1'b0;
  assign Skp_Inserted = 1'b0;
`endif

  assign at_last = (byte_idx_q == last_idx_q);
  assign accept  = TX_Valid & TX_Ready;

  // Word boundaries are the only points where a word or SKP set may start;
  // a pending SKP blocks acceptance there.
  always_comb begin
    TX_Ready = 1'b0;
    if (Rst_n) begin
      case (state_q)
        IDLE:    TX_Ready = !skp_due;
        SHIFT:   TX_Ready = at_last & !skp_due;
`ifdef TX_SKP_INSERT_EN
        SKP_SYM: TX_Ready = (skp_idx_q == SKP_LAST);
`endif
        default: TX_Ready = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge WordClk) begin
    word_q     <= word_d;
    wordk_q    <= wordk_d;
    last_idx_q <= last_idx_d;
    if (!Rst_n) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      data_out_q  <= '0;
      datak_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      data_out_q  <= data_out_d;
      datak_q     <= datak_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
`ifdef TX_SKP_INSERT_EN
    skp_idx_d  = skp_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (skp_due) begin
          state_d = SKP_COM;
        end else if (accept) begin
          state_d    = SHIFT;
          byte_idx_d = '0;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          byte_idx_d = byte_idx_q + 1'b1;
        end else if (skp_due) begin
          state_d = SKP_COM;
        end else if (accept) begin
          byte_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef TX_SKP_INSERT_EN
      SKP_COM: begin
        state_d   = SKP_SYM;
        skp_idx_d = '0;
      end
      SKP_SYM: begin
        if (skp_idx_q != SKP_LAST) begin
          skp_idx_d = skp_idx_q + 1'b1;
        end else if (accept) begin
          state_d    = SHIFT;
          byte_idx_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered outputs are loaded with what the next state drives.
  always_comb begin
    word_d      = accept ? TX_Data  : word_q;
    wordk_d     = accept ? TX_DataK : wordk_q;
    last_idx_d  = accept ? width_last(DataBusWidth) : last_idx_q;
    data_out_d  = 8'h00;
    datak_d     = 1'b0;
    out_valid_d = 1'b0;
`ifdef TX_SKP_INSERT_EN
    skp_ins_d   = 1'b0;
`endif
    case (state_d)
      SHIFT: begin
        data_out_d  = word_d[{byte_idx_d, 3'b000} +: 8];
        datak_d     = wordk_d[byte_idx_d];
        out_valid_d = 1'b1;
      end
`ifdef TX_SKP_INSERT_EN
      SKP_COM: begin
        data_out_d  = 8'hBC;
        datak_d     = 1'b1;
        out_valid_d = 1'b1;
        skp_ins_d   = 1'b1;
      end
      SKP_SYM: begin
        data_out_d  = 8'h1C;
        datak_d     = 1'b1;
        out_valid_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign Data_out  = data_out_q;
  assign DataK_out = datak_q;
  assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_pcs_tx_byte_sequencer.sv
module tb_pcs_tx_byte_sequencer;

  localparam int SKP_INTERVAL = 16;
  localparam int SKP_COUNT    = 3;
  localparam int CNT_W        = 11;
`ifdef TX_SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  width;
  logic [31:0] tx_data;
  logic [3:0]  tx_k;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  data_out;
  logic        datak_out;
  logic        out_valid;
  logic        skp_ins;

  always #5 clk = ~clk;

  pcs_tx_byte_sequencer #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .SKP_COUNT   (SKP_COUNT),
    .CNT_W       (CNT_W)
  ) dut (
    .WordClk     (clk),
    .Rst_n       (rst_n),
    .DataBusWidth(width),
    .TX_Data     (tx_data),
    .TX_DataK    (tx_k),
    .TX_Valid    (tx_valid),
    .TX_Ready    (tx_ready),
    .Data_out    (data_out),
    .DataK_out   (datak_out),
    .Out_Valid   (out_valid),
    .Skp_Inserted(skp_ins)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: the symbol currently on the wire plus a queue of
  // symbols still owed from the current word or SKP set.
  typedef struct packed {
    logic       vld;
    logic       skp;
    logic       com;
    logic       k;
    logic [7:0] b;
  } sym_t;

  sym_t cur;
  sym_t pend[$];
  int   since_com;
  logic acc_last;

  function automatic bit due();
    return SKP_ON && (since_com >= SKP_INTERVAL);
  endfunction

  function automatic bit exp_ready(input logic r);
    return r && (pend.size() == 0) && ((cur.vld && cur.skp) || !due());
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic [5:0] w);
    bit   rdy;
    bit   d_now;
    int   n;
    sym_t s;
    @(negedge clk);
    rst_n = r; tx_valid = v; tx_data = d; tx_k = k; width = w;
    #1;
    check("data_out",  data_out,  cur.b);
    check("datak_out", datak_out, cur.k);
    check("out_valid", out_valid, cur.vld);
    check("skp_ins",   skp_ins,   cur.com);
    rdy = exp_ready(r);
    check("tx_ready",  tx_ready,  rdy);
    @(posedge clk);
    acc_last = v && rdy;
    if (!r) begin
      cur = '0;
      pend.delete();
      since_com = 0;
    end else begin
      d_now = due();
      since_com = (since_com >= SKP_INTERVAL) ? SKP_INTERVAL : since_com + 1;
      if (pend.size() > 0) begin
        cur = pend.pop_front();
      end else if (d_now && !(cur.vld && cur.skp)) begin
        cur = '{vld:1'b1, skp:1'b1, com:1'b1, k:1'b1, b:8'hBC};
        for (int i = 0; i < SKP_COUNT; i++)
          pend.push_back('{vld:1'b1, skp:1'b1, com:1'b0, k:1'b1, b:8'h1C});
        since_com = 0;
      end else if (acc_last) begin
        n = (w == 6'd16) ? 2 : (w == 6'd32) ? 4 : 1;
        for (int i = 0; i < n; i++) begin
          s = '{vld:1'b1, skp:1'b0, com:1'b0, k:k[i], b:d[8*i +: 8]};
          pend.push_back(s);
        end
        cur = pend.pop_front();
      end else begin
        cur = '0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 6'd8);
  endtask

  logic [31:0] w16 [3];
  logic        hv;
  logic [31:0] hd;
  logic [3:0]  hk;
  logic [5:0]  hw;
  logic        hr;
  int          idx;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_k = '0; width = 6'd8;
    cur = '0; since_com = 0; acc_last = 1'b0;
    @(posedge clk);
    do_reset(3);

    // Single 32-bit word, then idle
    cycle(1'b1, 1'b1, 32'h4433_2211, 4'b0001, 6'd32);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 4'h0, 6'd32);

    // Three back-to-back 16-bit words with valid held high
    w16[0] = 32'h0000_A1B2; w16[1] = 32'h0000_C3D4; w16[2] = 32'h0000_E5F6;
    do_reset(1);
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, idx < 3, (idx < 3) ? w16[idx] : 32'h0, 4'b0010, 6'd16);
      if (acc_last) idx++;
    end

    // Reset while byte 2 of a 32-bit word is on the wire
    do_reset(1);
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 4'b1000, 6'd32);
    cycle(1'b1, 1'b0, 32'h0, 4'h0, 6'd32);
    cycle(1'b1, 1'b0, 32'h0, 4'h0, 6'd32);
    cycle(1'b0, 1'b0, 32'h0, 4'h0, 6'd32);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 4'h0, 6'd32);

    // Illegal width behaves as 8
    cycle(1'b1, 1'b1, 32'hAABB_CCDD, 4'b1111, 6'd24);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 4'h0, 6'd24);

    // Continuous 8-bit stream, then continuous 32-bit stream
    do_reset(1);
    hd = 32'h10;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b1, hd, 4'h0, 6'd8);
      if (acc_last) hd = hd + 1;
    end
    hd = 32'h0302_0100;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b1, hd, 4'b0100, 6'd32);
      if (acc_last) hd = hd + 32'h0404_0404;
    end

    // Randomized traffic with width changes and occasional resets
    hv = 1'b0; hd = '0; hk = '0; hw = 6'd8;
    for (int i = 0; i < 3000; i++) begin
      if (!(hv && !acc_last)) begin
        hv = ($urandom_range(0, 9) < 7);
        hd = $urandom;
        hk = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: hw = 6'd8;
          1: hw = 6'd16;
          2: hw = 6'd32;
          3: hw = 6'd24;
          default: hw = 6'd0;
        endcase
      end
      hr = ($urandom_range(0, 399) != 0);
      cycle(hr, hv, hd, hk, hw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
